// File: rtl/imm_extend_unit_if.sv
// rtl/imm_extend_unit_if.sv - request/result handshake bundle for imm_extend_unit
interface imm_extend_unit_if #(
    parameter int DATA_W  = 16,
    parameter int FIELD_W = 12
);
    logic               InValid;
    logic               InReady;
    logic [2:0]         Mode;
    logic [FIELD_W-1:0] Field;
    logic               OutValid;
    logic               OutReady;
    logic [DATA_W-1:0]  Immediate;
    logic               Prefixed;
    logic               ErrMode;

    modport master (
        output InValid, Mode, Field, OutReady,
        input  InReady, OutValid, Immediate, Prefixed, ErrMode
    );

    modport slave (
        input  InValid, Mode, Field, OutReady,
        output InReady, OutValid, Immediate, Prefixed, ErrMode
    );
endinterface

// File: rtl/imm_extend_unit.sv
// rtl/imm_extend_unit.sv - registered immediate extender, optional prefix FSM under IMMGEN_PREFIX_EN
module imm_extend_unit #(
    parameter int DATA_W  = 16,
    parameter int FIELD_W = 12
) (
    input  logic             CLK,
    input  logic             Reset,
    imm_extend_unit_if.slave bus
);
    localparam int PFX_W = DATA_W - 8;

    logic              accept;
    logic              load;
    logic              is_prefix;
    logic              use_pfx;
    logic              mode_reserved;
    logic              any_reserved;
    logic [DATA_W-1:0] ext_value;
    logic [DATA_W-1:0] load_value;

    logic              out_valid_q;
    logic [DATA_W-1:0] imm_q;
    logic              err_q;

    // A request can enter whenever the output slot is empty or being drained.
    assign bus.InReady = !Reset && (!bus.OutValid || bus.OutReady);
    assign accept      = bus.InValid && bus.InReady;

    // Per-mode extension of the raw field; modes 5..7 fall to the reserved arm.
    always_comb begin
        ext_value    = '0;
        any_reserved = 1'b0;
        case (bus.Mode)
            3'd0:    ext_value = DATA_W'($signed(bus.Field[3:0]));
            3'd1:    ext_value = DATA_W'($signed(bus.Field[7:0]));
            3'd2:    ext_value = DATA_W'($signed(bus.Field[11:0]));
            3'd3:    ext_value = DATA_W'(bus.Field[7:0]);
            3'd4:    ext_value = {bus.Field[7:0], {(DATA_W-8){1'b0}}};
            default: any_reserved = 1'b1;
        endcase
    end

    // Mode 5 is only a real operation when the prefix machinery exists.
    assign mode_reserved = any_reserved && !is_prefix;
    // PREFIX accepts never produce a result.
    assign load          = accept && !is_prefix;

`ifdef IMMGEN_PREFIX_EN
    typedef enum logic {IDLE, HELD} pfx_state_t;

    pfx_state_t       state_q;
    pfx_state_t       state_d;
    logic [PFX_W-1:0] pfx_q;
    logic [PFX_W-1:0] pfx_d;
    logic             prefixed_q;

    assign is_prefix = (bus.Mode == 3'd5);

    // Prefix state and held upper bits.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q <= IDLE;
            pfx_q   <= '0;
        end else begin
            state_q <= state_d;
            pfx_q   <= pfx_d;
        end
    end

    // Capture on PREFIX; a held prefix is consumed by the next valid-mode request,
    // while reserved modes leave it parked.
    always_comb begin
        state_d = state_q;
        pfx_d   = pfx_q;
        use_pfx = 1'b0;
        if (accept) begin
            if (is_prefix) begin
                pfx_d   = bus.Field[PFX_W-1:0];
                state_d = HELD;
            end else if (state_q == HELD && !mode_reserved) begin
                use_pfx = 1'b1;
                state_d = IDLE;
            end
        end
    end

    // Prefixed flag travels with the result register.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            prefixed_q <= 1'b0;
        end else if (load) begin
            prefixed_q <= use_pfx;
        end
    end

    assign bus.Prefixed = prefixed_q;
    assign load_value   = use_pfx ? {pfx_q, bus.Field[7:0]} : ext_value;
`else
    assign is_prefix    = 1'b0;
    assign use_pfx      = 1'b0;
    assign bus.Prefixed = 1'b0;
    assign load_value   = ext_value;
`endif

    // One-entry result register; data holds until reset or the next load.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            out_valid_q <= 1'b0;
            imm_q       <= '0;
            err_q       <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            imm_q       <= load_value;
            err_q       <= mode_reserved;
        end else if (out_valid_q && bus.OutReady) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.OutValid  = out_valid_q;
    assign bus.Immediate = imm_q;
    assign bus.ErrMode   = err_q;
endmodule

// File: tb/tb_imm_extend_unit.sv
// tb/tb_imm_extend_unit.sv - randomized and directed check of imm_extend_unit against a reference model
module tb_imm_extend_unit;
    localparam int DW = 16;
`ifdef IMMGEN_PREFIX_EN
    localparam bit PFX_EN = 1'b1;
`else
    localparam bit PFX_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic Reset;

    imm_extend_unit_if #(.DATA_W(DW), .FIELD_W(12)) bus ();

    imm_extend_unit #(.DATA_W(DW), .FIELD_W(12)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Reference state
    bit          m_ov  = 1'b0;
    int unsigned m_imm = 0;
    bit          m_pf  = 1'b0;
    bit          m_er  = 1'b0;
    bit          m_held = 1'b0;
    int unsigned m_pfx = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned model_ext(input int mode, input int f);
        int v;
        case (mode)
            0: v = (f % 16 >= 8) ? (f % 16) - 16 : f % 16;
            1: v = (f % 256 >= 128) ? (f % 256) - 256 : f % 256;
            2: v = (f >= 2048) ? f - 4096 : f;
            3: v = f % 256;
            4: v = (f % 256) * (1 << (DW - 8));
            default: v = 0;
        endcase
        return int'(v) & ((1 << DW) - 1);
    endfunction

    // One clock: drive inputs, check InReady, advance model, then check outputs.
    task automatic cycle(input bit rst, input bit iv, input int mode, input int field, input bit ordy);
        bit exp_ready;
        bit acc;
        bit reserved;
        Reset        = rst;
        bus.InValid  = iv;
        bus.Mode     = 3'(mode);
        bus.Field    = 12'(field);
        bus.OutReady = ordy;
        #1;
        exp_ready = !rst && (!m_ov || ordy);
        check_val("in_ready", bus.InReady, exp_ready);
        acc = iv && exp_ready;
        reserved = (mode >= 6) || (mode == 5 && !PFX_EN);
        if (rst) begin
            m_ov = 0; m_imm = 0; m_pf = 0; m_er = 0; m_held = 0; m_pfx = 0;
        end else if (acc && mode == 5 && PFX_EN) begin
            m_held = 1;
            m_pfx  = field % (1 << (DW - 8));
        end else if (acc) begin
            m_ov = 1;
            if (reserved) begin
                m_imm = 0; m_er = 1; m_pf = 0;
            end else if (m_held) begin
                m_imm = m_pfx * 256 + field % 256; m_pf = 1; m_er = 0; m_held = 0;
            end else begin
                m_imm = model_ext(mode, field); m_pf = 0; m_er = 0;
            end
        end else if (m_ov && ordy) begin
            m_ov = 0;
        end
        @(posedge CLK);
        @(negedge CLK);
        check_val("out_valid", bus.OutValid, m_ov);
        check_val("immediate", bus.Immediate, m_imm);
        check_val("prefixed", bus.Prefixed, m_pf);
        check_val("err_mode", bus.ErrMode, m_er);
    endtask

    initial begin
        Reset = 1'b1;
        bus.InValid = 1'b0;
        bus.Mode = 3'd0;
        bus.Field = 12'd0;
        bus.OutReady = 1'b1;

        cycle(1, 1, 2, 12'h800, 1);
        check_val("reset_imm", bus.Immediate, 0);
        cycle(0, 0, 0, 0, 1);

        cycle(0, 1, 0, 12'h008, 1); check_val("sext4_neg", bus.Immediate, 16'hFFF8);
        cycle(0, 1, 1, 12'h080, 1); check_val("sext8_neg", bus.Immediate, 16'hFF80);
        cycle(0, 1, 2, 12'h800, 1); check_val("sext12_neg", bus.Immediate, 16'hF800);
        cycle(0, 1, 4, 12'h080, 1); check_val("upper8_neg", bus.Immediate, 16'h8000);
        cycle(0, 1, 0, 12'h004, 1); check_val("sext4_pos", bus.Immediate, 16'h0004);
        cycle(0, 1, 1, 12'h040, 1); check_val("sext8_pos", bus.Immediate, 16'h0040);
        cycle(0, 1, 2, 12'h400, 1); check_val("sext12_pos", bus.Immediate, 16'h0400);
        cycle(0, 1, 4, 12'h040, 1); check_val("upper8_pos", bus.Immediate, 16'h4000);
        cycle(0, 1, 3, 12'h0F0, 1); check_val("zext8", bus.Immediate, 16'h00F0);
        cycle(0, 1, 1, 12'h0F0, 1); check_val("sext8_f0", bus.Immediate, 16'hFFF0);
        cycle(0, 0, 0, 0, 1);       check_val("drained", bus.OutValid, 0);

        cycle(0, 1, 5, 12'h0AB, 1);
        check_val("prefix_no_out", bus.OutValid, PFX_EN ? 1'b0 : 1'b1);
        cycle(0, 1, 0, 12'h0CD, 1);
        check_val("prefix_value", bus.Immediate, PFX_EN ? 16'hABCD : 16'hFFFD);
        check_val("prefix_flag", bus.Prefixed, PFX_EN);
        cycle(0, 1, 0, 12'h0CD, 1);
        check_val("post_prefix", bus.Immediate, 16'hFFFD);
        check_val("post_prefix_flag", bus.Prefixed, 0);

        cycle(0, 1, 4, 12'h012, 1); check_val("bp_load", bus.Immediate, 16'h1200);
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 2, 12'h777, 0);
            check_val("bp_hold", bus.Immediate, 16'h1200);
        end
        cycle(0, 1, 1, 12'h0FF, 1);
        check_val("bp_replace", bus.Immediate, 16'hFFFF);
        check_val("bp_valid", bus.OutValid, 1);

        cycle(0, 1, 5, 12'h012, 1);
        cycle(1, 1, 3, 12'h055, 1);
        check_val("rst_valid", bus.OutValid, 0);
        check_val("rst_imm", bus.Immediate, 0);
        cycle(0, 1, 3, 12'h034, 1);
        check_val("rst_zext", bus.Immediate, 16'h0034);
        check_val("rst_pfx", bus.Prefixed, 0);

        cycle(0, 1, 6, 12'hFFF, 1);
        check_val("mode6_imm", bus.Immediate, 0);
        check_val("mode6_err", bus.ErrMode, 1);
        cycle(0, 1, 5, 12'h0FF, 1);
        if (!PFX_EN) begin
            check_val("mode5_reserved", bus.ErrMode, 1);
        end
        cycle(0, 1, 7, 12'h001, 1);
        cycle(0, 1, 1, 12'h001, 1);

        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 4095)),
                  ($urandom_range(0, 3) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
